i2c_bus_arbiter: RTL and testbench
==================================

# i2c_bus_arbiter

Round-robin arbiter and transaction sequencer that shares one I2C master among N requesters. It sits between the requesting blocks and the I2C master, and runs entirely in the sys_clk domain. For each transaction it:
- picks a winner and latches that requester's address, R/W bit and write data onto the master command port;
- holds the master start strobe until the master reports busy, then waits for completion or timeout;
- returns a one-cycle done pulse with ACK status and read data, and enforces a bus-free gap before the next grant.

## Interface
- N, default 4: number of requesters, 2..8.
- GAP_CYC, default 16: sys_clk cycles of idle gap between transactions, ≥1.
- TIMEOUT_CYC, default 4096: sys_clk cycles allowed from launch to m_done before the transaction is aborted.
- sys_clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  N  per-requester request level; must be held until that requester's done.
- req_addr  in  7*N  flattened 7-bit target addresses; requester i uses bits [7i+6:7i].
- req_rw  in  N  per-requester R/W bit (1 = read).
- req_data  in  8*N  flattened write data; requester i uses bits [8i+7:8i].
- gnt  out  N  one-hot grant, held for the whole transaction.
- done  out  N  one-hot, one-cycle completion pulse.
- nack  out  1  status, valid while done is high: 1 = NACK or timeout.
- err  out  1  valid while done is high: 1 = timeout abort.
- rdata  out  8  read data, valid while done is high.
- busy  out  1  high in every state except IDLE.
- m_en  out  1  start strobe to the master.
- m_addr  out  7  command address to the master.
- m_rw  out  1  command R/W bit to the master.
- m_din  out  8  command write data to the master.
- m_abort  out  1  one-cycle abort pulse to the master.
- m_busy  in  1  master transaction in progress.
- m_done  in  1  one-cycle completion pulse from the master.
- m_nack  in  1  master ACK status, valid with m_done.
- m_rdata  in  8  master read data, valid with m_done.

## Operation
States: IDLE, LAUNCH, WAIT_DONE, RESP, GAP.
- **IDLE:** when req != 0, the winner is the first set bit searching upward from ptr, wrapping modulo N.
  - At the same edge: gnt is loaded with the one-hot winner; m_addr, m_rw and m_din are loaded from the winner's slice; m_en goes to 1; the timeout counter is cleared; the state goes to LAUNCH.
- **LAUNCH:** m_en is held at 1.
  - When m_busy is sampled 1: m_en goes to 0 and the state goes to WAIT_DONE.
  - If m_done is sampled 1 first (fast master): the state goes directly to RESP, exactly as from WAIT_DONE.
- **WAIT_DONE:** when m_done is sampled 1: done is loaded with onehot(winner), nack with m_nack, rdata with m_rdata, err with 0; the state goes to RESP.
- **Timeout (LAUNCH or WAIT_DONE):** the counter increments every cycle. If it reaches TIMEOUT_CYC-1 with m_done low:
  - done is pulsed for the winner, with nack=1 and err=1; rdata is unchanged;
  - m_abort is pulsed for 1 cycle and m_en is forced to 0;
  - the state goes to RESP.
  - If m_done and timeout fall on the same cycle, m_done wins: err=0.
- **RESP:** lasts 1 cycle. On exit, done and gnt clear, m_abort clears, ptr ← (winner+1) mod N, the gap counter is loaded, and the state goes to GAP.
- **GAP:** lasts GAP_CYC cycles, then the state goes to IDLE. Requests are ignored during GAP.
- Requests are sampled only in IDLE. A requester dropping req mid-transaction does not cancel it; the transaction completes and done still pulses.
- m_addr, m_rw and m_din hold their values from launch until the next launch.
- Counter widths: $clog2(TIMEOUT_CYC) and $clog2(GAP_CYC+1). ptr width is $clog2(N).

## Timing
- **Reset values:** gnt, done, nack, err, rdata, busy, m_en, m_addr, m_rw, m_din and m_abort are all 0; ptr=0; state=IDLE. This applies at any time, including mid-transaction; no done is issued for a transaction aborted by reset.
- **Request to launch:** req sampled at edge t puts gnt and m_en high after edge t (1-cycle latency).
- **m_en:** deasserts after the edge that samples m_busy=1.
- **Completion:** m_done sampled at edge d puts done high for exactly the cycle between edges d and d+1; gnt falls after edge d+1.
- **Turnaround:** the state is IDLE after edge d+1+GAP_CYC. A held request is granted at edge d+2+GAP_CYC.
- **Timeout:** 1 clock after edge L, m_en, gnt and the timeout counter are live. m_done still low ⇒ done/err/m_abort raised after edge L+TIMEOUT_CYC-1.

## Test plan
- **Single write:** N=4, GAP_CYC=4; req=0001, addr 0x50, rw=0, data 0xA5; m_busy at +2, m_done at +20 with nack=0 ⇒ m_addr=0x50, m_din=0xA5, m_en high 2 cycles, done=0001 for 1 cycle, nack=0, then gnt=0.
- **Round robin:** req=1111 held continuously ⇒ grants are 0001, 0010, 0100, 1000, 0001, each separated by RESP+GAP, exactly 6 cycles from m_done to the next gnt.
- **Read with NACK:** req=0100, rw=1; m_done with m_nack=1, m_rdata=0x3C ⇒ done=0100, nack=1, err=0, rdata=0x3C.
- **Timeout:** TIMEOUT_CYC=32; m_busy=1 and m_done never arrives ⇒ after 31 cycles done pulses with nack=1, err=1 and m_abort pulses for 1 cycle; the next requester is granted after the gap.
- **Coincident m_done and timeout:** m_done arrives on the same cycle the timeout fires ⇒ err=0, nack follows m_nack, no m_abort.
- **Reset mid-WAIT_DONE:** rst low ⇒ all outputs are 0 immediately and no done pulse is issued; after release with req=0010, grant starts from ptr=0 and gnt=0010.

Source files
------------

// File: rtl/i2c_bus_arbiter.sv
// i2c_bus_arbiter: round-robin arbiter and transaction sequencer that shares
// one I2C master among N requesters. It latches the winner's command onto the
// master port, supervises the transfer with a timeout, returns a one-cycle
// done pulse with status, and enforces a bus-free gap before the next grant.
//
// Handshakes:
//   requester side: a requester raises req with its addr/rw/data slice stable
//   and holds it until its done pulse; gnt stays high for the whole transaction
//   and done is a single-cycle pulse that qualifies nack, err and rdata.
//   master side: m_en is a level strobe held until m_busy is sampled high (or
//   m_done arrives first); m_done is a single-cycle pulse that qualifies m_nack
//   and m_rdata; m_abort is a single-cycle pulse issued only on timeout.
module i2c_bus_arbiter #(
  parameter int N           = 4,
  parameter int GAP_CYC     = 16,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic           sys_clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [7*N-1:0] req_addr,
  input  logic [N-1:0]   req_rw,
  input  logic [8*N-1:0] req_data,
  output logic [N-1:0]   gnt,
  output logic [N-1:0]   done,
  output logic           nack,
  output logic           err,
  output logic [7:0]     rdata,
  output logic           busy,
  output logic           m_en,
  output logic [6:0]     m_addr,
  output logic           m_rw,
  output logic [7:0]     m_din,
  output logic           m_abort,
  input  logic           m_busy,
  input  logic           m_done,
  input  logic           m_nack,
  input  logic [7:0]     m_rdata,
  output logic [2:0]     dbg_state
);

  localparam int PTR_W  = $clog2(N);
  localparam int TCNT_W = $clog2(TIMEOUT_CYC);
  localparam int GCNT_W = $clog2(GAP_CYC + 1);

  // The counter is cleared at launch and compared before it increments, so
  // matching TIMEOUT_CYC-2 here means it reaches TIMEOUT_CYC-1 at this edge,
  // which lands the abort TIMEOUT_CYC-1 cycles after the launch edge.
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYC - 2);
  localparam logic [GCNT_W-1:0] GCNT_LOAD = GCNT_W'(GAP_CYC - 1);
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LAUNCH    = 3'd1,
    S_WAIT_DONE = 3'd2,
    S_RESP      = 3'd3,
    S_GAP       = 3'd4
  } state_t;

  state_t              state;
  logic [PTR_W-1:0]    ptr;
  logic [PTR_W-1:0]    win_q;
  logic [TCNT_W-1:0]   tcnt;
  logic [GCNT_W-1:0]   gcnt;

  logic                win_found;
  logic [PTR_W-1:0]    win_idx;
  logic [PTR_W-1:0]    cand;
  logic [N-1:0]        win_onehot;
  logic [6:0]          sel_addr;
  logic                sel_rw;
  logic [7:0]          sel_data;

  assign dbg_state = state;

  // Round-robin search: first set request bit at or above ptr, wrapping mod N.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < N; k++) begin
      cand = PTR_W'((int'(ptr) + k) % N);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Decode the winner into a one-hot grant and pick out its command slice.
  always_comb begin
    win_onehot = '0;
    sel_addr   = '0;
    sel_rw     = 1'b0;
    sel_data   = '0;
    for (int i = 0; i < N; i++) begin
      if (win_idx == PTR_W'(i)) begin
        win_onehot[i] = 1'b1;
        sel_addr      = req_addr[7*i +: 7];
        sel_rw        = req_rw[i];
        sel_data      = req_data[8*i +: 8];
      end
    end
  end

  // Transaction sequencer: grant, launch, supervise, respond, then bus-free gap.
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      ptr     <= '0;
      win_q   <= '0;
      tcnt    <= '0;
      gcnt    <= '0;
      gnt     <= '0;
      done    <= '0;
      nack    <= 1'b0;
      err     <= 1'b0;
      rdata   <= '0;
      busy    <= 1'b0;
      m_en    <= 1'b0;
      m_addr  <= '0;
      m_rw    <= 1'b0;
      m_din   <= '0;
      m_abort <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (win_found) begin
            gnt    <= win_onehot;
            win_q  <= win_idx;
            m_addr <= sel_addr;
            m_rw   <= sel_rw;
            m_din  <= sel_data;
            m_en   <= 1'b1;
            tcnt   <= '0;
            busy   <= 1'b1;
            state  <= S_LAUNCH;
          end
        end

        S_LAUNCH, S_WAIT_DONE: begin
          tcnt <= tcnt + 1'b1;
          if (m_done) begin
            // A completion on the timeout cycle still counts as a completion.
            done  <= gnt;
            nack  <= m_nack;
            rdata <= m_rdata;
            err   <= 1'b0;
            m_en  <= 1'b0;
            state <= S_RESP;
          end else if (tcnt == TCNT_LAST) begin
            // Abort: rdata keeps its previous value, status reports failure.
            done    <= gnt;
            nack    <= 1'b1;
            err     <= 1'b1;
            m_abort <= 1'b1;
            m_en    <= 1'b0;
            state   <= S_RESP;
          end else if (state == S_LAUNCH && m_busy) begin
            m_en  <= 1'b0;
            state <= S_WAIT_DONE;
          end
        end

        S_RESP: begin
          done    <= '0;
          gnt     <= '0;
          m_abort <= 1'b0;
          ptr     <= (win_q == PTR_LAST) ? '0 : win_q + 1'b1;
          gcnt    <= GCNT_LOAD;
          state   <= S_GAP;
        end

        S_GAP: begin
          if (gcnt == '0) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            gcnt <= gcnt - 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// tb_i2c_bus_arbiter: directed bench for i2c_bus_arbiter with N=4, GAP_CYC=4,
// TIMEOUT_CYC=32. A table of transaction records drives a small master model
// and checks grant, command, done timing and status; hand-written sequences
// cover reset mid-transaction and continuous round-robin turnaround.
module tb_i2c_bus_arbiter;

  localparam int N   = 4;
  localparam int GAP = 4;
  localparam int TMO = 32;

  // clock / reset
  logic sys_clk;
  logic rst;

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic [N-1:0]   req;
  logic [7*N-1:0] req_addr;
  logic [N-1:0]   req_rw;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   gnt;
  logic [N-1:0]   done;
  logic           nack;
  logic           err;
  logic [7:0]     rdata;
  logic           busy;
  logic           m_en;
  logic [6:0]     m_addr;
  logic           m_rw;
  logic [7:0]     m_din;
  logic           m_abort;
  logic           m_busy;
  logic           m_done;
  logic           m_nack;
  logic [7:0]     m_rdata;
  logic [2:0]     dbg_state;

  i2c_bus_arbiter #(.N(N), .GAP_CYC(GAP), .TIMEOUT_CYC(TMO)) dut (
    .sys_clk   (sys_clk),
    .rst       (rst),
    .req       (req),
    .req_addr  (req_addr),
    .req_rw    (req_rw),
    .req_data  (req_data),
    .gnt       (gnt),
    .done      (done),
    .nack      (nack),
    .err       (err),
    .rdata     (rdata),
    .busy      (busy),
    .m_en      (m_en),
    .m_addr    (m_addr),
    .m_rw      (m_rw),
    .m_din     (m_din),
    .m_abort   (m_abort),
    .m_busy    (m_busy),
    .m_done    (m_done),
    .m_nack    (m_nack),
    .m_rdata   (m_rdata),
    .dbg_state (dbg_state)
  );

  // transaction record: stimulus plus hand-computed expectations
  typedef struct {
    logic [3:0]  rq;
    logic [27:0] addrs;
    logic [3:0]  rws;
    logic [31:0] datas;
    int          busy_at;
    int          done_at;
    logic        mnack;
    logic [7:0]  mrdata;
    logic [3:0]  e_gnt;
    logic [6:0]  e_addr;
    logic        e_rw;
    logic [7:0]  e_din;
    int          e_done_at;
    int          e_en;
    logic        e_nack;
    logic        e_err;
    logic [7:0]  e_rdata;
    logic        e_abort;
  } vec_t;

  localparam logic [27:0] ADDRS  = {7'h2B, 7'h1C, 7'h68, 7'h50};
  localparam logic [31:0] DATAS  = {8'hD4, 8'h0F, 8'h96, 8'hA5};
  localparam logic [31:0] DATAS2 = {8'hD4, 8'h0F, 8'h96, 8'h3E};

  vec_t vecs[7];
  vec_t post_rst;

  int compared   = 0;
  int mismatched = 0;

  // scoreboard compare
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver + master model for one transaction; called at a negedge with DUT idle
  task automatic run_txn(input vec_t v, input string tag);
    int en_cyc;
    bit seen;
    en_cyc = 0;
    seen   = 1'b0;
    req_addr = v.addrs;
    req_rw   = v.rws;
    req_data = v.datas;
    m_nack   = v.mnack;
    m_rdata  = v.mrdata;
    req      = v.rq;
    @(negedge sys_clk);
    check({tag, "_gnt"},    64'(gnt),    64'(v.e_gnt));
    check({tag, "_m_addr"}, 64'(m_addr), 64'(v.e_addr));
    check({tag, "_m_rw"},   64'(m_rw),   64'(v.e_rw));
    check({tag, "_m_din"},  64'(m_din),  64'(v.e_din));
    check({tag, "_busy"},   64'(busy),   64'd1);
    for (int j = 0; j < 100; j++) begin
      if (j == v.e_done_at) begin
        seen = 1'b1;
        check({tag, "_done"},    64'(done),    64'(v.e_gnt));
        check({tag, "_nack"},    64'(nack),    64'(v.e_nack));
        check({tag, "_err"},     64'(err),     64'(v.e_err));
        check({tag, "_rdata"},   64'(rdata),   64'(v.e_rdata));
        check({tag, "_m_abort"}, 64'(m_abort), 64'(v.e_abort));
        check({tag, "_m_en_off"}, 64'(m_en),   64'd0);
        break;
      end
      if (done != '0) begin
        check({tag, "_early_done"}, 64'(done), 64'd0);
        break;
      end
      if (m_en) en_cyc++;
      m_busy = (j + 1 >= v.busy_at) && (v.done_at == 0 || j + 1 < v.done_at);
      m_done = (j + 1 == v.done_at);
      @(negedge sys_clk);
    end
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    check({tag, "_m_en_cyc"}, 64'(en_cyc), 64'(v.e_en));
    m_busy = 1'b0;
    m_done = 1'b0;
    req    = '0;
    @(negedge sys_clk);
    check({tag, "_done_1cyc"}, 64'(done),    64'd0);
    check({tag, "_gnt_clr"},   64'(gnt),     64'd0);
    check({tag, "_abort_clr"}, 64'(m_abort), 64'd0);
    check({tag, "_m_addr_hold"}, 64'(m_addr), 64'(v.e_addr));
    repeat (GAP - 1) @(negedge sys_clk);
    check({tag, "_gap_busy"}, 64'(busy), 64'd1);
    @(negedge sys_clk);
    check({tag, "_idle_busy"},  64'(busy),      64'd0);
    check({tag, "_idle_state"}, 64'(dbg_state), 64'd0);
  endtask

  // watchdog
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish by %0t", $time);
    $fatal(1, "watchdog expired");
  end

  // main test
  initial begin
    int cnt;
    bit any_done;
    logic [3:0] exp_g;

    vecs[0] = '{rq:4'b0001, addrs:ADDRS, rws:4'b0000, datas:DATAS, busy_at:2, done_at:20, mnack:1'b0, mrdata:8'h00,
                e_gnt:4'b0001, e_addr:7'h50, e_rw:1'b0, e_din:8'hA5, e_done_at:20, e_en:2, e_nack:1'b0, e_err:1'b0, e_rdata:8'h00, e_abort:1'b0};
    vecs[1] = '{rq:4'b0100, addrs:ADDRS, rws:4'b0100, datas:DATAS, busy_at:2, done_at:10, mnack:1'b1, mrdata:8'h3C,
                e_gnt:4'b0100, e_addr:7'h1C, e_rw:1'b1, e_din:8'h0F, e_done_at:10, e_en:2, e_nack:1'b1, e_err:1'b0, e_rdata:8'h3C, e_abort:1'b0};
    vecs[2] = '{rq:4'b0011, addrs:ADDRS, rws:4'b0000, datas:DATAS, busy_at:1, done_at:5, mnack:1'b0, mrdata:8'h5A,
                e_gnt:4'b0001, e_addr:7'h50, e_rw:1'b0, e_din:8'hA5, e_done_at:5, e_en:1, e_nack:1'b0, e_err:1'b0, e_rdata:8'h5A, e_abort:1'b0};
    vecs[3] = '{rq:4'b1010, addrs:ADDRS, rws:4'b1010, datas:DATAS, busy_at:9, done_at:3, mnack:1'b0, mrdata:8'h81,
                e_gnt:4'b0010, e_addr:7'h68, e_rw:1'b1, e_din:8'h96, e_done_at:3, e_en:3, e_nack:1'b0, e_err:1'b0, e_rdata:8'h81, e_abort:1'b0};
    vecs[4] = '{rq:4'b1000, addrs:ADDRS, rws:4'b0000, datas:DATAS, busy_at:2, done_at:0, mnack:1'b0, mrdata:8'hEE,
                e_gnt:4'b1000, e_addr:7'h2B, e_rw:1'b0, e_din:8'hD4, e_done_at:31, e_en:2, e_nack:1'b1, e_err:1'b1, e_rdata:8'h81, e_abort:1'b1};
    vecs[5] = '{rq:4'b0001, addrs:ADDRS, rws:4'b0001, datas:DATAS, busy_at:2, done_at:31, mnack:1'b0, mrdata:8'h77,
                e_gnt:4'b0001, e_addr:7'h50, e_rw:1'b1, e_din:8'hA5, e_done_at:31, e_en:2, e_nack:1'b0, e_err:1'b0, e_rdata:8'h77, e_abort:1'b0};
    vecs[6] = '{rq:4'b0001, addrs:ADDRS, rws:4'b0000, datas:DATAS2, busy_at:1, done_at:4, mnack:1'b1, mrdata:8'hC3,
                e_gnt:4'b0001, e_addr:7'h50, e_rw:1'b0, e_din:8'h3E, e_done_at:4, e_en:1, e_nack:1'b1, e_err:1'b0, e_rdata:8'hC3, e_abort:1'b0};
    post_rst = '{rq:4'b0010, addrs:ADDRS, rws:4'b0000, datas:DATAS, busy_at:2, done_at:6, mnack:1'b0, mrdata:8'h11,
                e_gnt:4'b0010, e_addr:7'h68, e_rw:1'b0, e_din:8'h96, e_done_at:6, e_en:2, e_nack:1'b0, e_err:1'b0, e_rdata:8'h11, e_abort:1'b0};

    rst      = 1'b0;
    req      = '0;
    req_addr = '0;
    req_rw   = '0;
    req_data = '0;
    m_busy   = 1'b0;
    m_done   = 1'b0;
    m_nack   = 1'b0;
    m_rdata  = '0;

    // reset state
    @(negedge sys_clk);
    @(negedge sys_clk);
    check("reset_outputs", 64'({gnt, done, nack, err, rdata, busy, m_en, m_addr, m_rw, m_din, m_abort}), 64'd0);
    check("reset_state", 64'(dbg_state), 64'd0);
    rst = 1'b1;
    @(negedge sys_clk);

    // table-driven transactions
    for (int i = 0; i < 7; i++) begin
      run_txn(vecs[i], $sformatf("v%0d", i));
    end

    // reset in the middle of WAIT_DONE (ptr is 1, so req 0100 wins)
    req_addr = ADDRS;
    req_rw   = 4'b0000;
    req_data = DATAS;
    m_nack   = 1'b0;
    m_rdata  = 8'h99;
    req      = 4'b0100;
    @(negedge sys_clk);
    check("mid_gnt", 64'(gnt), 64'b0100);
    m_busy = 1'b1;
    repeat (3) @(negedge sys_clk);
    check("mid_state_wait", 64'(dbg_state), 64'd2);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_outputs", 64'({gnt, done, nack, err, rdata, busy, m_en, m_addr, m_rw, m_din, m_abort}), 64'd0);
    check("mid_rst_state", 64'(dbg_state), 64'd0);
    req    = '0;
    m_busy = 1'b0;
    @(negedge sys_clk);
    @(negedge sys_clk);
    rst = 1'b1;
    any_done = 1'b0;
    repeat (6) begin
      @(negedge sys_clk);
      if (done != '0) any_done = 1'b1;
    end
    check("mid_rst_no_done", 64'(any_done), 64'd0);
    run_txn(post_rst, "post_rst");

    // round robin with all requests held, starting from a fresh pointer
    rst = 1'b0;
    @(negedge sys_clk);
    rst = 1'b1;
    req_addr = ADDRS;
    req_rw   = 4'b0000;
    req_data = DATAS;
    m_nack   = 1'b0;
    req      = 4'b1111;
    @(negedge sys_clk);
    for (int g = 0; g < 5; g++) begin
      exp_g = 4'b0001 << (g % 4);
      check($sformatf("rr%0d_gnt", g), 64'(gnt), 64'(exp_g));
      m_busy = 1'b1;
      @(negedge sys_clk);
      m_busy  = 1'b0;
      m_done  = 1'b1;
      m_rdata = 8'(g + 8'h40);
      @(negedge sys_clk);
      check($sformatf("rr%0d_done", g), 64'(done), 64'(exp_g));
      check($sformatf("rr%0d_rdata", g), 64'(rdata), 64'(g + 8'h40));
      m_done = 1'b0;
      if (g == 4) begin
        req = '0;
      end else begin
        cnt = 0;
        do begin
          @(negedge sys_clk);
          cnt++;
        end while (gnt == '0 && cnt < 20);
        check($sformatf("rr%0d_turnaround", g), 64'(cnt), 64'd6);
      end
    end
    repeat (GAP + 1) @(negedge sys_clk);
    check("rr_end_idle", 64'(busy), 64'd0);
    check("rr_end_gnt", 64'(gnt), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
